// File: rtl/dcache_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Purpose  : Direct-mapped write-through, no-write-allocate data cache
//            controller in front of a four-word block-read data memory.
//            Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
module dcache_ctrl #(
    parameter int INDEX_BITS  = 3,
    parameter int FILL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic        cpu_byte,
    output logic [31:0] cpu_rd,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic        mem_ren,
    output logic        mem_byte,
    input  logic [31:0] mem_d0,
    input  logic [31:0] mem_d1,
    input  logic [31:0] mem_d2,
    input  logic [31:0] mem_d3
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int c_LINES = 1 << INDEX_BITS;
    localparam int c_TAG_W = 28 - INDEX_BITS;
    localparam int c_CNT_W = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t                 state_q;
    logic [c_CNT_W-1:0]     cnt_q;
    logic [c_LINES-1:0]     valid_q;
    logic [c_TAG_W-1:0]     tag_q  [c_LINES];
    logic [31:0]            data_q [c_LINES][4];

    logic [INDEX_BITS-1:0]  w_index;
    logic [c_TAG_W-1:0]     w_tag;
    logic [1:0]             w_word;
    logic [1:0]             w_off;
    logic                   w_hit;
    logic [31:0]            w_rword;
    logic [7:0]             w_rbyte;
    logic                   w_fill_done;
    logic                   w_wr_hit;

    assign w_index     = cpu_addr[3+INDEX_BITS:4];
    assign w_tag       = cpu_addr[31:4+INDEX_BITS];
    assign w_word      = cpu_addr[3:2];
    assign w_off       = cpu_addr[1:0];
    assign w_hit       = valid_q[w_index] && (tag_q[w_index] == w_tag);
    assign w_rword     = data_q[w_index][w_word];
    assign w_rbyte     = w_rword[{w_off, 3'b000} +: 8];
    assign w_fill_done = (state_q == S_FILL) && (cnt_q == '0);
    assign w_wr_hit    = (state_q == S_IDLE) && cpu_we && w_hit;

    // Control state and valid bits; reset wins over a fill in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!cpu_we && cpu_re && !w_hit) begin
                        state_q <= S_FILL;
                        cnt_q   <= c_CNT_W'(FILL_CYCLES - 1);
                    end
                end
                S_FILL: begin
                    if (cnt_q == '0) begin
                        state_q          <= S_IDLE;
                        valid_q[w_index] <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_fill_done) begin
                tag_q[w_index]     <= w_tag;
                data_q[w_index][0] <= mem_d0;
                data_q[w_index][1] <= mem_d1;
                data_q[w_index][2] <= mem_d2;
                data_q[w_index][3] <= mem_d3;
            end else if (w_wr_hit) begin
                if (cpu_byte) begin
                    data_q[w_index][w_word][{w_off, 3'b000} +: 8] <= cpu_wd[7:0];
                end else begin
                    data_q[w_index][w_word] <= cpu_wd;
                end
            end
        end
    end

    always_comb begin
        stall    = 1'b0;
        mem_ren  = 1'b0;
        mem_we   = 1'b0;
        cpu_rd   = '0;
        mem_addr = cpu_addr;
        mem_wd   = cpu_wd;
        mem_byte = cpu_byte;
        if (!rst) begin
            if (state_q == S_FILL) begin
                stall    = 1'b1;
                mem_ren  = 1'b1;
                mem_addr = {cpu_addr[31:4], 4'b0000};
                mem_byte = 1'b0;
            end else if (cpu_we) begin
                mem_we = 1'b1;
            end else if (cpu_re) begin
                if (w_hit) begin
                    cpu_rd = cpu_byte ? {24'h0, w_rbyte} : w_rword;
                end else begin
                    stall = 1'b1;
                end
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic        replay_q;
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;
    logic        w_rd_idle;

    assign w_rd_idle  = (state_q == S_IDLE) && !cpu_we && cpu_re;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    // The replay of a just-filled request is not a genuine hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            replay_q     <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            replay_q <= w_fill_done;
            if (w_rd_idle && !w_hit && (miss_count_q != 32'hFFFF_FFFF)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
            if (w_rd_idle && w_hit && !replay_q && (hit_count_q != 32'hFFFF_FFFF)) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Purpose  : Randomised scoreboard bench for dcache_ctrl against a memory-level
//            reference model (write-through cache must always mirror memory).
// Revision : 1.0
// ============================================================================
module tb_dcache_ctrl;

    localparam int IB = 3;
    localparam int FC = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr, cpu_wd;
    logic        cpu_we, cpu_re, cpu_byte;
    logic [31:0] cpu_rd, mem_addr, mem_wd;
    logic        stall, mem_we, mem_ren, mem_byte;
    logic [31:0] mem_d0, mem_d1, mem_d2, mem_d3;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    dcache_ctrl #(.INDEX_BITS(IB), .FILL_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_byte(cpu_byte), .cpu_rd(cpu_rd), .stall(stall),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_ren(mem_ren),
        .mem_byte(mem_byte),
        .mem_d0(mem_d0), .mem_d1(mem_d1), .mem_d2(mem_d2), .mem_d3(mem_d3)
`ifdef DCACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] ba);
        return (ba * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Emulated data_memory, written only by the DUT's write port.
    logic [31:0] emem [logic [31:0]];
    // Reference memory, written by the stimulus.
    logic [31:0] rmem [logic [31:0]];

    function automatic logic [31:0] emem_rd(input logic [31:0] ba);
        logic [31:0] a = {ba[31:2], 2'b00};
        return emem.exists(a) ? emem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] rmem_rd(input logic [31:0] ba);
        logic [31:0] a = {ba[31:2], 2'b00};
        return rmem.exists(a) ? rmem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] ba,
                                          input logic [31:0] wd, input logic byt);
        logic [31:0] sh = 32'(ba[1:0]) * 8;
        if (!byt) return wd;
        return (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    endfunction

    always @(negedge clk) begin
        mem_d0 = emem_rd({mem_addr[31:4], 4'h0});
        mem_d1 = emem_rd({mem_addr[31:4], 4'h4});
        mem_d2 = emem_rd({mem_addr[31:4], 4'h8});
        mem_d3 = emem_rd({mem_addr[31:4], 4'hC});
    end

    always @(posedge clk) begin
        if (!rst && mem_we)
            emem[{mem_addr[31:2], 2'b00}] = merge(emem_rd(mem_addr), mem_addr, mem_wd, mem_byte);
    end

    // Reference model: which line each index holds, plus hit/miss tallies.
    logic [31:0] resident [int];
    int m_hits = 0;
    int m_misses = 0;

    typedef struct { logic [31:0] rd; int stalls; logic [31:0] line; } rexp_t;
    typedef struct { logic [31:0] addr; logic [31:0] wd; logic byt; } wexp_t;
    rexp_t rq[$];
    wexp_t wq[$];

    task automatic do_read(input logic [31:0] addr, input logic byt);
        rexp_t e;
        int idx = int'(addr[3+IB:4]);
        logic [31:0] line = {addr[31:4], 4'h0};
        logic [31:0] w = rmem_rd(addr);
        bit hit = resident.exists(idx) && (resident[idx] == line);
        e.rd     = byt ? ((w >> (32'(addr[1:0]) * 8)) & 32'hFF) : w;
        e.stalls = hit ? 0 : FC + 1;
        e.line   = line;
        rq.push_back(e);
        if (hit) m_hits++;
        else begin
            m_misses++;
            resident[idx] = line;
        end
        @(posedge clk); #1;
        cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = addr; cpu_byte = byt;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (!stall) break;
            if (n > 40) begin
                fail_now("read_timeout");
                break;
            end
        end
        @(posedge clk); #1;
        cpu_re = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] wd, input logic byt);
        wexp_t e;
        e.addr = addr; e.wd = wd; e.byt = byt;
        wq.push_back(e);
        rmem[{addr[31:2], 2'b00}] = merge(rmem_rd(addr), addr, wd, byt);
        @(posedge clk); #1;
        cpu_we = 1'b1; cpu_re = 1'b0; cpu_addr = addr; cpu_wd = wd; cpu_byte = byt;
        @(posedge clk); #1;
        cpu_we = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        check("rst_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        resident.delete();
        m_hits = 0;
        m_misses = 0;
    endtask

    // Monitor: pops expectations whenever the DUT completes a load or issues a store.
    bit    mon_en = 1'b0;
    int    stall_run = 0;
    rexp_t m_r;
    wexp_t m_w;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (cpu_we) begin
                if (wq.size() == 0) fail_now("store_unexpected");
                else begin
                    m_w = wq.pop_front();
                    check("store_we", {31'h0, mem_we}, 32'h1);
                    check("store_addr", mem_addr, m_w.addr);
                    check("store_wd", mem_wd, m_w.wd);
                    check("store_byte", {31'h0, mem_byte}, {31'h0, m_w.byt});
                    check("store_stall", {31'h0, stall}, 32'h0);
                end
            end else if (cpu_re) begin
                if (stall) begin
                    stall_run++;
                    if (mem_ren) begin
                        if (rq.size() == 0) fail_now("fill_unexpected");
                        else check("fill_addr", mem_addr, rq[0].line);
                    end
                end else if (rq.size() == 0) begin
                    fail_now("load_unexpected");
                end else begin
                    m_r = rq.pop_front();
                    check("load_data", cpu_rd, m_r.rd);
                    check("load_stall_cycles", stall_run, m_r.stalls);
                    check("load_ren", {31'h0, mem_ren}, 32'h0);
                    stall_run = 0;
                end
            end else begin
                check("idle_rd", cpu_rd, 32'h0);
                check("idle_stall", {31'h0, stall}, 32'h0);
                check("idle_ren", {31'h0, mem_ren}, 32'h0);
                check("idle_we", {31'h0, mem_we}, 32'h0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst = 1'b1; cpu_addr = '0; cpu_wd = '0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_byte = 1'b0;
        foreach (emem[k]) emem.delete(k);
        emem[32'h10000] = 32'h1122_3344; rmem[32'h10000] = 32'h1122_3344;
        emem[32'h10004] = 32'h5566_7788; rmem[32'h10004] = 32'h5566_7788;
        emem[32'h10008] = 32'h99AA_BBCC; rmem[32'h10008] = 32'h99AA_BBCC;
        emem[32'h1000C] = 32'hDDEE_FF00; rmem[32'h1000C] = 32'hDDEE_FF00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_stall", {31'h0, stall}, 32'h0);
        check("reset_ren", {31'h0, mem_ren}, 32'h0);
        check("reset_we", {31'h0, mem_we}, 32'h0);
        check("reset_rd", cpu_rd, 32'h0);
`ifdef DCACHE_STATS_EN
        @(posedge clk); #1;
        check("reset_hits", hit_count, 32'h0);
        check("reset_misses", miss_count, 32'h0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        do_read(32'h10000, 1'b0);
        do_read(32'h1000C, 1'b0);
        do_read(32'h10001, 1'b1);
        do_write(32'h10004, 32'hDEAD_BEEF, 1'b0);
        do_read(32'h10004, 1'b0);
        do_write(32'h10004, 32'h0000_00AA, 1'b1);
        do_read(32'h10004, 1'b0);
        check("byte_merge_model", rmem_rd(32'h10004), 32'hDEAD_BEAA);
        do_write(32'h20000, 32'h1357_9BDF, 1'b0);
        do_read(32'h20000, 1'b0);

        do_reset();
        do_read(32'h10000, 1'b0);
        do_read(32'h10080, 1'b0);
        do_read(32'h10000, 1'b0);
`ifdef DCACHE_STATS_EN
        @(negedge clk);
        check("conflict_misses", miss_count, 32'd3);
        check("conflict_hits", hit_count, 32'd0);
`endif

        for (int i = 0; i < 300; i++) begin
            a = 32'h10000 + 32'($urandom_range(0, 2)) * 32'h80
                + 32'($urandom_range(0, 7)) * 32'h10 + 32'($urandom_range(0, 3)) * 32'h4;
            if ($urandom_range(0, 1) == 1) begin
                a = a + 32'($urandom_range(0, 3));
                if ($urandom_range(0, 9) < 6) do_read(a, 1'b1);
                else do_write(a, $urandom, 1'b1);
            end else begin
                if ($urandom_range(0, 9) < 6) do_read(a, 1'b0);
                else do_write(a, $urandom, 1'b0);
            end
        end
`ifdef DCACHE_STATS_EN
        @(negedge clk);
        check("rand_hits", hit_count, 32'(m_hits));
        check("rand_misses", miss_count, 32'(m_misses));
`endif

        // Reset in the middle of a fill must leave the line invalid.
        do_read(32'h10080, 1'b0);
        mon_en = 1'b0;
        @(posedge clk); #1;
        cpu_re = 1'b1; cpu_addr = 32'h10000; cpu_byte = 1'b0;
        @(negedge clk);
        check("midfill_miss_stall", {31'h0, stall}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("midfill_ren", {31'h0, mem_ren}, 32'h1);
        check("midfill_addr", mem_addr, 32'h10000);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cpu_re = 1'b0;
        @(negedge clk);
        check("after_rst_stall", {31'h0, stall}, 32'h0);
        check("after_rst_ren", {31'h0, mem_ren}, 32'h0);
        resident.delete();
        m_hits = 0;
        m_misses = 0;
        mon_en = 1'b1;
        do_read(32'h10000, 1'b0);

        repeat (3) @(posedge clk);
        check("rq_drained", 32'(rq.size()), 32'h0);
        check("wq_drained", 32'(wq.size()), 32'h0);
`ifdef DCACHE_STATS_EN
        check("final_misses", miss_count, 32'd1);
        check("final_hits", hit_count, 32'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
